// File: rtl/deser_pkg.sv
// Shared definitions for the serial-to-parallel deserializer:
// FSM state encoding and the bit-counter width helper.
package deser_pkg;

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAR   = 2'd2;

  typedef enum logic [1:0] {
    HUNT  = ST_HUNT,   // waiting for the first start-of-frame
    SHIFT = ST_SHIFT,  // collecting data bits
    PAR   = ST_PAR     // collecting the parity bit (parity builds only)
  } deser_state_t;

  // Bits needed to count bit positions 0..width-1 (never less than one).
  function automatic int count_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/deser_shift_core.sv
// Shift register and bit counter for the deserializer.
// A bit is written straight to its final position in the word, so the
// bit order (LSB- or MSB-first) costs nothing but the index calculation.
// word_next is the word including the bit being taken this cycle, which
// lets the top register a completed word on the same edge as its last bit.
module deser_shift_core
  import deser_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int CW        = count_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             take,       // capture ser_in this cycle
  input  logic             first,      // captured bit is bit 0 of a new word
  output logic [WIDTH-1:0] word_q,     // word assembled so far
  output logic [WIDTH-1:0] word_next,  // word including this cycle's bit
  output logic [CW-1:0]    count,      // bits already held for the current word
  output logic             done        // this cycle's bit completes the word
);

  logic [CW-1:0] pos;
  logic [CW-1:0] idx;
  logic [CW-1:0] count_nxt;

  // Position of the incoming bit, the updated word and the next count.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    pos       = first ? '0 : count;
    idx       = MSB_FIRST ? (CW'(WIDTH - 1) - pos) : pos;
    word_next = first ? '0 : word_q;
    word_next[idx] = ser_in;
    done      = take && (pos == CW'(WIDTH - 1));
    count_nxt = done ? '0 : (pos + CW'(1));
  end

  // Commit the captured bit and the advanced count.
  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples its inputs from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      count  <= '0;
    end else if (take) begin
      word_q <= word_next;
      count  <= count_nxt;
    end
  end

endmodule

// File: rtl/param_deserializer.sv
// Parametrised serial-to-parallel converter with frame sync, bit-enable
// and a 1-deep valid/ready output register.
// Optional feature: define PARITY_CHECK_EN to expect an even-parity bit
// after every word; bad words are dropped and flagged on parity_err.
module param_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic             sync_err,
  output logic             parity_err
);

  localparam int CW = count_width(WIDTH);

  deser_state_t     state_q;
  logic             take;
  logic             first;
  logic             resync;
  logic             deliver;
  logic             par_bad;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    count;
  logic             core_done;

  deser_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .ser_in    (ser_in),
    .take      (take),
    .first     (first),
    .word_q    (word_q),
    .word_next (word_next),
    .count     (count),
    .done      (core_done)
  );

  // A word finishing on a data bit is still in flight (word_next); one
  // finishing on its parity bit is already stored in the core (word_q).
  assign cand = (state_q == PAR) ? word_q : word_next;

  // Decode this cycle's serial bit into core controls and word events.
  always_comb begin
    take    = 1'b0;
    first   = 1'b0;
    resync  = 1'b0;
    deliver = 1'b0;
    par_bad = 1'b0;
    case (state_q)
      HUNT: begin
        if (bit_valid && sof) begin
          take  = 1'b1;
          first = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          take   = 1'b1;
          first  = sof;
          resync = sof && (count != '0);
`ifndef PARITY_CHECK_EN
          deliver = core_done;
`endif
        end
      end
      PAR: begin
        if (bit_valid) begin
          if (sof) begin
            // A new frame instead of a parity bit abandons the stored word.
            take   = 1'b1;
            first  = 1'b1;
            resync = 1'b1;
          end else if (^{word_q, ser_in}) begin
            par_bad = 1'b1;
          end else begin
            deliver = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // FSM transitions, output register, handshake and event pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= HUNT;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      sync_err   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      case (state_q)
        HUNT:  if (bit_valid && sof) state_q <= SHIFT;
`ifdef PARITY_CHECK_EN
        SHIFT: if (core_done) state_q <= PAR;
        PAR:   if (bit_valid) state_q <= SHIFT;
`else
        SHIFT: state_q <= SHIFT;
`endif
        default: state_q <= HUNT;
      endcase

      overrun    <= 1'b0;
      sync_err   <= resync;
      parity_err <= par_bad;

      // The register may refill in the same cycle its word is taken.
      if (deliver && (!data_valid || data_ready)) begin
        data_out   <= cand;
        data_valid <= 1'b1;
      end else begin
        if (deliver) overrun <= 1'b1;
        if (data_valid && data_ready) data_valid <= 1'b0;
      end
    end
  end

endmodule
